// File: rtl/prod_acc.sv
// prod_acc: accumulates N unsigned 16-bit products into a saturating
// SUMW-bit sum, then holds the result until downstream takes it.
module prod_acc #(
    parameter int unsigned N    = 8,
    parameter int unsigned SUMW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     p,
    input  logic            p_valid,
    output logic            p_ready,
    input  logic            clr,
    output logic [SUMW-1:0] sum,
    output logic            ovf,
    output logic            sum_valid,
    input  logic            sum_ready
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [SUMW-1:0] SUM_MAX = '1;
    // Count value at which the next accept completes the batch.
    localparam logic [7:0]      N_LAST  = 8'(N - 1);

    state_t          state;
    state_t          state_next;
    logic [7:0]      count;
    logic [7:0]      count_next;
    logic [SUMW-1:0] sum_q;
    logic [SUMW-1:0] sum_next;
    logic            ovf_q;
    logic            ovf_next;
    logic [SUMW:0]   add_full;

    // One extra bit catches the carry that signals saturation.
    assign add_full = {1'b0, sum_q} + {{(SUMW + 1 - 16){1'b0}}, p};

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            count <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            sum_q <= sum_next;
            ovf_q <= ovf_next;
        end
    end

    // Next-state logic: clr first, then accept in ACC or release in DONE.
    always_comb begin
        state_next = state;
        count_next = count;
        sum_next   = sum_q;
        ovf_next   = ovf_q;
        if (clr) begin
            state_next = ACC;
            count_next = '0;
            sum_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (p_valid) begin
                        count_next = count + 8'd1;
                        if (add_full[SUMW]) begin
                            sum_next = SUM_MAX;
                            ovf_next = 1'b1;
                        end else begin
                            sum_next = add_full[SUMW-1:0];
                        end
                        if (count == N_LAST) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state_next = ACC;
                        count_next = '0;
                        sum_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = ACC;
                end
            endcase
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        p_ready   = (state == ACC);
        sum_valid = (state == DONE);
        sum       = sum_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_prod_acc.sv
// tb_prod_acc: three instances (N=8/SUMW=24, N=4/SUMW=17, N=1/SUMW=24)
// checked each cycle against a batch-level model, plus directed literals
// and an in-order scoreboard on the N=1 instance.
module tb_prod_acc;

    logic        clk;
    logic        rst_n;
    logic [15:0] p  [3];
    logic        pv [3];
    logic        clr[3];
    logic        sr [3];

    logic        pr_a, sv_a, ovf_a;
    logic        pr_b, sv_b, ovf_b;
    logic        pr_c, sv_c, ovf_c;
    logic [23:0] sum_a;
    logic [16:0] sum_b;
    logic [23:0] sum_c;

    int checks = 0;
    int errors = 0;

    prod_acc #(.N(8), .SUMW(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .p(p[0]), .p_valid(pv[0]), .p_ready(pr_a),
        .clr(clr[0]), .sum(sum_a), .ovf(ovf_a), .sum_valid(sv_a), .sum_ready(sr[0])
    );
    prod_acc #(.N(4), .SUMW(17)) dut_b (
        .clk(clk), .rst_n(rst_n), .p(p[1]), .p_valid(pv[1]), .p_ready(pr_b),
        .clr(clr[1]), .sum(sum_b), .ovf(ovf_b), .sum_valid(sv_b), .sum_ready(sr[1])
    );
    prod_acc #(.N(1), .SUMW(24)) dut_c (
        .clk(clk), .rst_n(rst_n), .p(p[2]), .p_valid(pv[2]), .p_ready(pr_c),
        .clr(clr[2]), .sum(sum_c), .ovf(ovf_c), .sum_valid(sv_c), .sum_ready(sr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Batch-level model: unsaturated running total and item count per batch;
    // a batch is pending once it holds N items.
    int unsigned nn   [3] = '{8, 4, 1};
    longint      maxv [3] = '{64'd16777215, 64'd131071, 64'd16777215};
    int unsigned m_cnt[3] = '{0, 0, 0};
    longint      m_tot[3] = '{0, 0, 0};
    bit          m_pend[3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || clr[i] || (m_pend[i] && sr[i])) begin
                m_cnt[i]  = 0;
                m_tot[i]  = 0;
                m_pend[i] = 0;
            end else if (!m_pend[i] && pv[i]) begin
                m_tot[i] += longint'(p[i]);
                m_cnt[i]++;
                if (m_cnt[i] == nn[i]) m_pend[i] = 1;
            end
        end
    end

    // Scoreboard for the N=1 instance.
    longint sb_q[$];
    int     n_acc = 0;
    int     n_rel = 0;

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        longint gs[3];
        logic   gpr[3], gsv[3], gov[3];
        longint exp_s;
        gs[0] = longint'(sum_a); gs[1] = longint'(sum_b); gs[2] = longint'(sum_c);
        gpr[0] = pr_a; gpr[1] = pr_b; gpr[2] = pr_c;
        gsv[0] = sv_a; gsv[1] = sv_b; gsv[2] = sv_c;
        gov[0] = ovf_a; gov[1] = ovf_b; gov[2] = ovf_c;
        for (int i = 0; i < 3; i++) begin
            exp_s = (m_tot[i] > maxv[i]) ? maxv[i] : m_tot[i];
            chk($sformatf("model_p_ready[%0d]", i), longint'(gpr[i]), longint'(!m_pend[i]));
            chk($sformatf("model_sum_valid[%0d]", i), longint'(gsv[i]), longint'(m_pend[i]));
            chk($sformatf("model_sum[%0d]", i), gs[i], exp_s);
            chk($sformatf("model_ovf[%0d]", i), longint'(gov[i]), longint'(m_tot[i] > maxv[i]));
        end
        if (rst_n && !clr[2]) begin
            if (sv_c && sr[2]) begin
                n_rel++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", longint'(sum_c), -1);
                end else begin
                    chk("sb_order", longint'(sum_c), sb_q.pop_front());
                end
            end
            if (pr_c && pv[2]) begin
                sb_q.push_back(longint'(p[2]));
                n_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int rel0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p[i] = '0; pv[i] = 1'b0; clr[i] = 1'b0; sr[i] = 1'b0;
        end
        step();
        step();
        rst_n = 1'b1;
        chk("reset_p_ready", longint'(pr_a), 1);
        chk("reset_sum_valid", longint'(sv_a), 0);
        chk("reset_sum", longint'(sum_a), 0);
        chk("reset_ovf", longint'(ovf_b), 0);

        // 1..8 back-to-back, downstream always ready.
        sr[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            p[0] = 16'(k); pv[0] = 1'b1;
            step();
        end
        pv[0] = 1'b0;
        chk("seq_sum", longint'(sum_a), 36);
        chk("seq_sum_valid", longint'(sv_a), 1);
        chk("seq_ovf", longint'(ovf_a), 0);
        chk("seq_p_ready_low", longint'(pr_a), 0);
        step();
        chk("seq_p_ready_back", longint'(pr_a), 1);
        chk("seq_released", longint'(sv_a), 0);

        // 255*255 eight times with backpressure.
        sr[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p[0] = 16'd65025; pv[0] = 1'b1;
            step();
        end
        pv[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("hold_sum", longint'(sum_a), 520200);
            chk("hold_ovf", longint'(ovf_a), 0);
            chk("hold_valid", longint'(sv_a), 1);
            if (c == 5) sr[0] = 1'b1;
            step();
        end
        chk("hold_released", longint'(sv_a), 0);
        chk("hold_cleared", longint'(sum_a), 0);

        // Saturation on SUMW=17, N=4.
        sr[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p[1] = 16'hFFFF; pv[1] = 1'b1;
            step();
            if (k == 1) begin
                chk("sat_partial_sum", longint'(sum_b), 131070);
                chk("sat_partial_ovf", longint'(ovf_b), 0);
            end
            if (k == 2) chk("sat_early_ovf", longint'(ovf_b), 1);
        end
        pv[1] = 1'b0;
        chk("sat_sum", longint'(sum_b), 131071);
        chk("sat_ovf", longint'(ovf_b), 1);
        sr[1] = 1'b1;
        step();
        p[1] = 16'd5; pv[1] = 1'b1;
        step();
        chk("sat_next_sum", longint'(sum_b), 5);
        chk("sat_next_ovf", longint'(ovf_b), 0);
        for (int k = 0; k < 3; k++) step();
        pv[1] = 1'b0;
        chk("sat_next_batch", longint'(sum_b), 20);
        step();

        // clr mid-batch drops the offered product.
        sr[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            p[0] = 16'd7; pv[0] = 1'b1;
            step();
        end
        p[0] = 16'd100; clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("clr_sum", longint'(sum_a), 0);
        chk("clr_p_ready", longint'(pr_a), 1);
        for (int k = 0; k < 8; k++) begin
            p[0] = 16'd10; pv[0] = 1'b1;
            step();
        end
        pv[0] = 1'b0;
        chk("clr_result", longint'(sum_a), 80);
        chk("clr_valid", longint'(sv_a), 1);
        sr[0] = 1'b1;
        step();

        // Asynchronous reset mid-batch.
        for (int k = 0; k < 3; k++) begin
            p[0] = 16'd3; pv[0] = 1'b1;
            step();
        end
        pv[0] = 1'b0;
        chk("pre_rst_sum", longint'(sum_a), 9);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_sum", longint'(sum_a), 0);
        chk("async_rst_valid", longint'(sv_a), 0);
        chk("async_rst_p_ready", longint'(pr_a), 1);
        chk("async_rst_ovf", longint'(ovf_a), 0);
        step();
        rst_n = 1'b1;
        p[0] = 16'd9; pv[0] = 1'b1;
        step();
        pv[0] = 1'b0;
        chk("first_accept_after_rst", longint'(sum_a), 9);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;

        // N=1 throughput: one result per two cycles.
        rel0 = n_rel;
        sr[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            p[2] = 16'(1000 + k); pv[2] = 1'b1;
            step();
        end
        chk("n1_throughput", longint'(n_rel - rel0), 3);

        // N=1 random handshakes.
        for (int k = 0; k < 300; k++) begin
            p[2]  = 16'($urandom);
            pv[2] = 1'($urandom_range(0, 1));
            sr[2] = 1'($urandom_range(0, 1));
            step();
        end
        pv[2] = 1'b0; sr[2] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("sb_leftover", longint'(sb_q.size()), 0);
        chk("sb_acc_eq_rel", longint'(n_acc), longint'(n_rel));
        chk("sb_some_traffic", longint'(n_acc > 10), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
